mem_access_unit: RTL and testbench

- Data-memory side of the MemRead/MemWrite 2-bit control codes produced by the main decoder.
  - 00 = none, 01 = word, 10 = byte, 11 = half.
- Sits in the MEM stage. Turns a decoded load/store into a req/ack bus transaction with byte enables and lane steering.
- Stalls the pipeline until the bus completes, then returns a sign- or zero-extended load result.

---
 rtl/mem_access_unit.sv | 219 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns decoded MemRead/MemWrite codes into a req/ack bus access with lane steering.
// Optional: define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of ignoring the low address bits.
module mem_access_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mem_read,
    input  logic [1:0]        mem_write,
    input  logic              load_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err,
    output logic              illegal_op,
    output logic              misalign
);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       SZ_WORD  = 2'b01;
    localparam logic [1:0]       SZ_BYTE  = 2'b10;
    localparam logic [1:0]       SZ_HALF  = 2'b11;

    typedef enum logic [1:0] { IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2 } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        lane_q, lane_d;
    logic              is_load_q, is_load_d;
    logic              uns_q, uns_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              bus_err_q, bus_err_d;
    logic              illegal_q, illegal_d;
    logic              misalign_q, misalign_d;
    logic              stall_c;

    logic        rd_op, wr_op, op_illegal, op_misalign;
    logic [1:0]  op_size;
    logic [3:0]  op_be;
    logic [31:0] op_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;

    // Incoming-op decode: byte enables and replicated store lanes.
    always_comb begin
        rd_op      = (mem_read != 2'b00);
        wr_op      = (mem_write != 2'b00);
        op_illegal = rd_op && wr_op;
        op_size    = rd_op ? mem_read : mem_write;
        op_be      = 4'b0000;
        op_wdata   = 32'h0;
        case (op_size)
            SZ_WORD: begin op_be = 4'b1111;                      op_wdata = wdata;                  end
            SZ_BYTE: begin op_be = 4'b0001 << addr[1:0];         op_wdata = {4{wdata[7:0]}};        end
            SZ_HALF: begin op_be = addr[1] ? 4'b1100 : 4'b0011;  op_wdata = {2{wdata[15:0]}};       end
            default: begin op_be = 4'b0000;                      op_wdata = 32'h0;                  end
        endcase
`ifdef MISALIGN_TRAP_EN
        op_misalign = ((op_size == SZ_HALF) && addr[0]) ||
                      ((op_size == SZ_WORD) && (addr[1:0] != 2'b00));
`else
        op_misalign = 1'b0;
`endif
    end

    // Load lane selection and extension from the latched access attributes.
    always_comb begin
        ld_byte  = bus_rdata[{lane_q, 3'b000} +: 8];
        ld_half  = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        load_val = bus_rdata;
        case (size_q)
            SZ_BYTE: load_val = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: load_val = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_val = bus_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        size_d        = size_q;
        lane_d        = lane_q;
        is_load_d     = is_load_q;
        uns_d         = uns_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_be_d      = bus_be_q;
        bus_wdata_d   = bus_wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        bus_err_d     = 1'b0;
        illegal_d     = 1'b0;
        misalign_d    = 1'b0;
        stall_c       = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_op || wr_op) begin
                    stall_c = 1'b1;
                    if (op_illegal || op_misalign) begin
                        // Rejected access: no bus cycle, loads still complete with zero.
                        state_d    = RESP;
                        illegal_d  = op_illegal;
                        misalign_d = op_misalign;
                        if (rd_op) begin
                            rdata_d       = 32'h0;
                            rdata_valid_d = 1'b1;
                        end
                    end else begin
                        state_d     = REQ;
                        cnt_d       = '0;
                        size_d      = op_size;
                        lane_d      = addr[1:0];
                        is_load_d   = rd_op;
                        uns_d       = load_unsigned;
                        bus_req_d   = 1'b1;
                        bus_we_d    = wr_op;
                        bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                        bus_be_d    = op_be;
                        bus_wdata_d = op_wdata;
                    end
                end
            end
            REQ: begin
                stall_c = 1'b1;
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    state_d   = RESP;
                    if (is_load_q) begin
                        rdata_d       = load_val;
                        rdata_valid_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = RESP;
                    if (is_load_q) begin
                        rdata_d       = 32'h0;
                        rdata_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            size_q        <= 2'b00;
            lane_q        <= 2'b00;
            is_load_q     <= 1'b0;
            uns_q         <= 1'b0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_be_q      <= 4'b0000;
            bus_wdata_q   <= 32'h0;
            rdata_q       <= 32'h0;
            rdata_valid_q <= 1'b0;
            bus_err_q     <= 1'b0;
            illegal_q     <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            size_q        <= size_d;
            lane_q        <= lane_d;
            is_load_q     <= is_load_d;
            uns_q         <= uns_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_be_q      <= bus_be_d;
            bus_wdata_q   <= bus_wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            bus_err_q     <= bus_err_d;
            illegal_q     <= illegal_d;
            misalign_q    <= misalign_d;
        end
    end

    // Stall is combinational in IDLE, so it is masked while reset holds every output low.
    assign stall       = rst_n & stall_c;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_err     = bus_err_q;
    assign illegal_op  = illegal_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed plan cases plus randomized ops against a reference model.
module tb_mem_access_unit;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mem_read, mem_write;
    logic        load_unsigned;
    logic [31:0] addr, wdata;
    logic        stall, rdata_valid, bus_req, bus_we, bus_err, illegal_op, misalign;
    logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_ack;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_rdata = 32'h0;

    mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata), .stall(stall),
        .rdata(rdata), .rdata_valid(rdata_valid), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .bus_err(bus_err), .illegal_op(illegal_op), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall0;
        int          stall_cnt;
        int          req_cnt;
        logic        we;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic        stable;
        logic        rv;
        logic [31:0] rd;
        logic        err;
        logic        ill;
        logic        mis;
        logic        extra;
        logic [31:0] rd_after;
        logic        hung;
    } obs_t;

    // Reference model: what one access should look like from the outside.
    function automatic obs_t model_op(input logic [1:0] rd, input logic [1:0] wr, input logic uns,
                                      input logic [31:0] a, input logic [31:0] wd,
                                      input logic [31:0] rbus, input int ack_dly,
                                      input logic [31:0] prev);
        obs_t e;
        logic [1:0]  size;
        logic        is_load, trap, on_bus, acked;
        logic [31:0] v;
        int          sh;
        e = '{default: 0};
        size    = (rd != 0) ? rd : wr;
        is_load = (rd != 0);
        e.ill   = (rd != 0) && (wr != 0);
`ifdef MISALIGN_TRAP_EN
        trap = ((size == 2'd3) && (a % 2 != 0)) || ((size == 2'd1) && (a % 4 != 0));
`else
        trap = 1'b0;
`endif
        e.mis   = !e.ill && trap;
        on_bus  = !e.ill && !trap;
        acked   = on_bus && (ack_dly >= 0) && (ack_dly < TIMEOUT);
        e.err   = on_bus && !acked;
        e.req_cnt   = !on_bus ? 0 : (acked ? ack_dly + 1 : TIMEOUT);
        e.stall0    = 1'b1;
        e.stall_cnt = 1 + e.req_cnt;
        e.we    = !is_load;
        e.baddr = a - (a % 4);
        case (size)
            2'd1: begin e.be = 4'hF; e.bwd = wd; end
            2'd2: begin e.be = 4'(1 << (a % 4)); e.bwd = (wd & 32'hFF) * 32'h01010101; end
            default: begin e.be = ((a / 2) % 2 != 0) ? 4'hC : 4'h3; e.bwd = (wd & 32'hFFFF) * 32'h00010001; end
        endcase
        v = 32'h0;
        if (acked) begin
            case (size)
                2'd1: v = rbus;
                2'd2: begin
                    sh = 8 * int'(a % 4);
                    v  = (rbus >> sh) & 32'hFF;
                    if (!uns && v >= 128) v = v + 32'hFFFFFF00;
                end
                default: begin
                    sh = ((a / 2) % 2 != 0) ? 16 : 0;
                    v  = (rbus >> sh) & 32'hFFFF;
                    if (!uns && v >= 32768) v = v + 32'hFFFF0000;
                end
            endcase
        end
        e.rv       = is_load;
        e.rd       = is_load ? v : prev;
        e.rd_after = e.rd;
        e.stable   = 1'b1;
        e.extra    = 1'b0;
        e.hung     = 1'b0;
        return e;
    endfunction

    // Driver: presents one op, acts as the bus slave, records what the DUT did.
    task automatic drive_op(input logic [1:0] rd, input logic [1:0] wr, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rbus,
                            input int ack_dly, output obs_t o);
        int n;
        bit got_resp;
        o = '{default: 0};
        o.stable = 1'b1;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; load_unsigned = uns; addr = a; wdata = wd;
        bus_rdata = rbus; bus_ack = 1'b0;
        @(negedge clk);
        o.stall0    = stall;
        o.stall_cnt = (stall === 1'b1) ? 1 : 0;
        n = 0;
        got_resp = 0;
        while (!got_resp && n < 64) begin
            @(posedge clk); #1;
            bus_ack = 1'b0;
            if (bus_req === 1'b1) begin
                if (o.req_cnt == 0) begin
                    o.we = bus_we; o.baddr = bus_addr; o.be = bus_be; o.bwd = bus_wdata;
                end else if (bus_we !== o.we || bus_addr !== o.baddr || bus_be !== o.be || bus_wdata !== o.bwd) begin
                    o.stable = 1'b0;
                end
                bus_ack = (ack_dly >= 0) && (o.req_cnt == ack_dly);
                o.req_cnt++;
            end
            @(negedge clk);
            if (stall === 1'b1) o.stall_cnt++;
            else begin
                got_resp = 1;
                o.rv = rdata_valid; o.rd = rdata; o.err = bus_err; o.ill = illegal_op; o.mis = misalign;
            end
            n++;
        end
        o.hung = !got_resp;
        @(posedge clk); #1;
        mem_read = 2'b00; mem_write = 2'b00; bus_ack = 1'b0;
        @(negedge clk);
        o.extra    = rdata_valid | bus_err | illegal_op | misalign | stall | bus_req;
        o.rd_after = rdata;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; mem_read = 2'b00; mem_write = 2'b00; load_unsigned = 1'b0;
        addr = 32'h0; wdata = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({stall, rdata_valid, bus_req, bus_we, bus_err, illegal_op, misalign} !== 7'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000000", {stall, rdata_valid, bus_req, bus_we, bus_err, illegal_op, misalign}); end
        checks++; if ({rdata, bus_addr, bus_wdata, bus_be} !== 100'h0) begin
            errors++; $display("FAIL reset_data: rdata=%h bus_addr=%h bus_wdata=%h bus_be=%b expected all 0", rdata, bus_addr, bus_wdata, bus_be); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        checks++; if (stall !== 1'b0 || bus_req !== 1'b0) begin
            errors++; $display("FAIL reset_release: stall=%b bus_req=%b expected 0 0", stall, bus_req); end
    endtask

    task automatic test_sb;
        obs_t o;
        drive_op(2'b00, 2'b10, 1'b0, 32'h1003, 32'h000000A5, 32'h0, 2, o);
        checks++; if (o.be !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b expected 1000", o.be); end
        checks++; if (o.bwd !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", o.bwd); end
        checks++; if (o.baddr !== 32'h1000 || o.we !== 1'b1) begin errors++; $display("FAIL sb_addr: got %h we=%b expected 1000 we=1", o.baddr, o.we); end
        checks++; if (o.stall_cnt != 4 || o.stall0 !== 1'b1) begin errors++; $display("FAIL sb_stall: got %0d cycles expected 4", o.stall_cnt); end
        checks++; if (o.rv !== 1'b0 || o.rd !== exp_rdata || o.extra !== 1'b0) begin
            errors++; $display("FAIL sb_resp: rv=%b rd=%h extra=%b expected 0 %h 0", o.rv, o.rd, o.extra, exp_rdata); end
    endtask

    task automatic test_load_ext;
        obs_t o;
        drive_op(2'b10, 2'b00, 1'b0, 32'h2001, 32'h0, 32'h1234F0AB, 0, o);
        checks++; if (o.rv !== 1'b1 || o.rd !== 32'hFFFFFFF0) begin errors++; $display("FAIL lb_signed: got rv=%b %h expected 1 fffffff0", o.rv, o.rd); end
        checks++; if (o.stall_cnt != 2) begin errors++; $display("FAIL lb_latency: got %0d stall cycles expected 2", o.stall_cnt); end
        drive_op(2'b10, 2'b00, 1'b1, 32'h2001, 32'h0, 32'h1234F0AB, 1, o);
        checks++; if (o.rv !== 1'b1 || o.rd !== 32'h000000F0) begin errors++; $display("FAIL lbu: got rv=%b %h expected 1 000000f0", o.rv, o.rd); end
        checks++; if (o.rd_after !== 32'h000000F0 || o.extra !== 1'b0) begin errors++; $display("FAIL lbu_hold: got %h extra=%b expected 000000f0 0", o.rd_after, o.extra); end
        drive_op(2'b11, 2'b00, 1'b0, 32'h2002, 32'h0, 32'h8001FFFF, 0, o);
        checks++; if (o.rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_data: got %h expected ffff8001", o.rd); end
        checks++; if (o.be !== 4'b1100 || o.we !== 1'b0) begin errors++; $display("FAIL lh_be: got %b we=%b expected 1100 we=0", o.be, o.we); end
        exp_rdata = 32'hFFFF8001;
    endtask

    task automatic test_timeout;
        obs_t o;
        drive_op(2'b01, 2'b00, 1'b0, 32'h0000_4448, 32'h0, 32'hDEADBEEF, -1, o);
        checks++; if (o.req_cnt != TIMEOUT) begin errors++; $display("FAIL to_req_cycles: got %0d expected %0d", o.req_cnt, TIMEOUT); end
        checks++; if (o.err !== 1'b1 || o.rv !== 1'b1 || o.rd !== 32'h0) begin
            errors++; $display("FAIL to_resp: err=%b rv=%b rd=%h expected 1 1 0", o.err, o.rv, o.rd); end
        checks++; if (o.extra !== 1'b0 || o.hung) begin errors++; $display("FAIL to_release: extra=%b hung=%b expected 0 0", o.extra, o.hung); end
        // Ack on the very last allowed cycle still completes normally.
        drive_op(2'b01, 2'b00, 1'b0, 32'h0000_4450, 32'h0, 32'hCAFEF00D, TIMEOUT - 1, o);
        checks++; if (o.req_cnt != TIMEOUT || o.err !== 1'b0 || o.rd !== 32'hCAFEF00D) begin
            errors++; $display("FAIL to_last_ack: req=%0d err=%b rd=%h expected %0d 0 cafef00d", o.req_cnt, o.err, o.rd, TIMEOUT); end
        exp_rdata = 32'hCAFEF00D;
    endtask

    task automatic test_illegal;
        obs_t o;
        drive_op(2'b01, 2'b01, 1'b0, 32'h5000, 32'h11112222, 32'h33334444, 0, o);
        checks++; if (o.ill !== 1'b1 || o.req_cnt != 0) begin errors++; $display("FAIL illegal: ill=%b req_cycles=%0d expected 1 0", o.ill, o.req_cnt); end
        checks++; if (o.rv !== 1'b1 || o.rd !== 32'h0 || o.extra !== 1'b0) begin
            errors++; $display("FAIL illegal_resp: rv=%b rd=%h extra=%b expected 1 0 0", o.rv, o.rd, o.extra); end
        exp_rdata = 32'h0;
    endtask

    task automatic test_misalign;
        obs_t o;
        drive_op(2'b01, 2'b00, 1'b0, 32'h3002, 32'h0, 32'h89ABCDEF, 0, o);
`ifdef MISALIGN_TRAP_EN
        checks++; if (o.mis !== 1'b1 || o.req_cnt != 0 || o.rd !== 32'h0) begin
            errors++; $display("FAIL misalign_trap: mis=%b req=%0d rd=%h expected 1 0 0", o.mis, o.req_cnt, o.rd); end
        exp_rdata = 32'h0;
`else
        checks++; if (o.baddr !== 32'h3000 || o.be !== 4'hF || o.mis !== 1'b0) begin
            errors++; $display("FAIL misalign_ignore: addr=%h be=%b mis=%b expected 3000 1111 0", o.baddr, o.be, o.mis); end
        checks++; if (o.rd !== 32'h89ABCDEF) begin errors++; $display("FAIL misalign_data: got %h expected 89abcdef", o.rd); end
        exp_rdata = 32'h89ABCDEF;
`endif
    endtask

    task automatic test_reset_mid_req;
        @(posedge clk); #1;
        mem_read = 2'b01; mem_write = 2'b00; addr = 32'h4000; bus_ack = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL midrst_pre: bus_req=%b expected 1", bus_req); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus_req !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL midrst_async: bus_req=%b stall=%b expected 0 0", bus_req, stall); end
        mem_read = 2'b00; bus_ack = 1'b1; bus_rdata = 32'h12345678;
        @(posedge clk); #2; rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++; if (bus_req !== 1'b0 || rdata_valid !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0) begin
                errors++; $display("FAIL midrst_ack_ignored: req=%b rv=%b stall=%b rd=%h expected 0 0 0 0", bus_req, rdata_valid, stall, rdata); end
        end
        @(posedge clk); #1; bus_ack = 1'b0;
        exp_rdata = 32'h0;
    endtask

    task automatic test_random;
        obs_t o, e;
        logic [1:0]  rd, wr;
        logic [31:0] a, wd, rb;
        logic        uns;
        int          kind, ad, r;
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 9));
            rd = 2'(int'($urandom_range(1, 3)));
            wr = 2'(int'($urandom_range(1, 3)));
            if (kind >= 1 && kind <= 5) wr = 2'b00;
            else if (kind >= 6) rd = 2'b00;
            a = $urandom; wd = $urandom; rb = $urandom; uns = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            ad = (r == 0) ? -1 : (r == 1) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
            e = model_op(rd, wr, uns, a, wd, rb, ad, exp_rdata);
            drive_op(rd, wr, uns, a, wd, rb, ad, o);
            checks++; if (o.hung) begin errors++; $display("FAIL rnd%0d hung: no response within budget", i); end
            checks++; if (o.stall0 !== 1'b1 || o.stall_cnt != e.stall_cnt) begin
                errors++; $display("FAIL rnd%0d stall: got %0d expected %0d", i, o.stall_cnt, e.stall_cnt); end
            checks++; if (o.req_cnt != e.req_cnt) begin errors++; $display("FAIL rnd%0d req_cycles: got %0d expected %0d", i, o.req_cnt, e.req_cnt); end
            if (e.req_cnt > 0) begin
                checks++; if (o.we !== e.we || o.baddr !== e.baddr || o.be !== e.be || o.bwd !== e.bwd) begin
                    errors++; $display("FAIL rnd%0d bus: we=%b addr=%h be=%b wd=%h expected %b %h %b %h",
                                       i, o.we, o.baddr, o.be, o.bwd, e.we, e.baddr, e.be, e.bwd); end
                checks++; if (o.stable !== 1'b1) begin errors++; $display("FAIL rnd%0d bus_stable: got 0 expected 1", i); end
            end
            checks++; if (o.rv !== e.rv || o.rd !== e.rd) begin
                errors++; $display("FAIL rnd%0d rdata: rv=%b rd=%h expected %b %h", i, o.rv, o.rd, e.rv, e.rd); end
            checks++; if (o.err !== e.err || o.ill !== e.ill || o.mis !== e.mis) begin
                errors++; $display("FAIL rnd%0d pulses: err=%b ill=%b mis=%b expected %b %b %b", i, o.err, o.ill, o.mis, e.err, e.ill, e.mis); end
            checks++; if (o.extra !== 1'b0 || o.rd_after !== e.rd_after) begin
                errors++; $display("FAIL rnd%0d after: extra=%b rd=%h expected 0 %h", i, o.extra, o.rd_after, e.rd_after); end
            exp_rdata = e.rd;
        end
    endtask

    initial begin
        test_reset();
        test_sb();
        test_load_ext();
        test_timeout();
        test_illegal();
        test_misalign();
        test_reset_mid_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
